// File: rtl/fetch_controller.sv
// fetch_controller: IDLE/REQ/VALID/FAULT instruction fetch FSM with redirect and valid/ready hand-off to decode.
// Optional macro FETCH_TIMEOUT_EN adds a REQ-cycle watchdog that enters a sticky FAULT state.
module fetch_controller #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_instruction_request,
   output logic [31:0] o_mem_pc,
   input  logic [31:0] i_instruction,
   input  logic        i_awk,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   output logic        o_valid,
   input  logic        i_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_fault
);

   typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] redirect_target;
   logic        unused_bits;

   assign redirect_target       = {i_redirect_pc[31:2], 2'b00};
   assign unused_bits           = ^i_redirect_pc[1:0];
   assign o_instruction_request = (state == REQ);
   assign o_valid               = (state == VALID);
   assign o_mem_pc              = {2'b00, pc[31:2]};

`ifdef FETCH_TIMEOUT_EN
   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] tcnt;
   logic          expired;

   // True in the REQ cycle whose increment brings the counter to TIMEOUT_CYCLES
   assign expired = (tcnt == TLIM);
   assign o_fault = (state == FAULT);
`else
   logic unused_cfg;

   assign unused_cfg = ^TIMEOUT_CYCLES;
   assign o_fault    = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         o_instr    <= '0;
         o_instr_pc <= '0;
`ifdef FETCH_TIMEOUT_EN
         tcnt       <= '0;
`endif
      end else if (i_redirect && (state != IDLE)) begin
         // Redirect wins over ack and ready: a coincident instruction is dropped
         state <= REQ;
         pc    <= redirect_target;
`ifdef FETCH_TIMEOUT_EN
         tcnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
`ifdef FETCH_TIMEOUT_EN
               tcnt  <= '0;
`endif
            end
            REQ: begin
               if (i_awk) begin
                  o_instr    <= i_instruction;
                  o_instr_pc <= pc;
                  state      <= VALID;
               end
`ifdef FETCH_TIMEOUT_EN
               else begin
                  if (expired)
                     state <= FAULT;
                  if (tcnt != TMAX)
                     tcnt <= tcnt + 1'b1;
               end
`endif
            end
            VALID: begin
               if (i_ready) begin
                  pc    <= pc + 32'd4;
                  state <= REQ;
`ifdef FETCH_TIMEOUT_EN
                  tcnt  <= '0;
`endif
               end
            end
            FAULT:   state <= FAULT;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte PC loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: REQ cycles without i_awk before fault; only used with FETCH_TIMEOUT_EN.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 o_instruction_request  out  1  request to program memory.
REQ-006 o_mem_pc  out  32  word index to program memory, {2'b00, pc[31:2]}.
REQ-007 i_instruction  in  32  instruction returned by program memory.
REQ-008 i_awk  in  1  memory acknowledge; i_instruction valid when high.
REQ-009 o_instr  out  32  instruction to decode.
REQ-010 o_instr_pc  out  32  byte PC of o_instr.
REQ-011 o_valid  out  1  o_instr/o_instr_pc valid.
REQ-012 i_ready  in  1  decode accepts o_instr this cycle.
REQ-013 i_redirect  in  1  branch/jump/trap redirect.
REQ-014 i_redirect_pc  in  32  redirect target, byte address.
REQ-015 o_fault  out  1  fetch timeout fault, sticky.

Function
REQ-016 States: IDLE, REQ, VALID, FAULT; registered state, one transition max per cycle.
REQ-017 IDLE: entered only from reset; outputs inactive; next cycle -> REQ.
REQ-018 REQ: o_instruction_request=1, o_mem_pc from current pc; on i_awk=1 capture i_instruction into o_instr, pc into o_instr_pc, -> VALID.
REQ-019 Request is combinational from state; deasserts in the cycle after i_awk is sampled.
REQ-020 VALID: o_valid=1, o_instruction_request=0, o_instr/o_instr_pc held stable while i_ready=0.
REQ-021 VALID with i_ready=1: pc <= pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), -> REQ; o_valid=0 next cycle.
REQ-022 Throughput: one instruction per 3 cycles minimum with zero-wait memory (REQ, ack, VALID/accept).
REQ-023 i_redirect=1 has top priority in every state except IDLE: pc <= {i_redirect_pc[31:2],2'b00}, o_valid=0 next cycle, -> REQ.
REQ-024 Redirect in same cycle as i_awk: returned instruction discarded, not presented.
REQ-025 Redirect in same cycle as i_ready in VALID: instruction counted accepted, pc takes redirect target, not pc+4.
REQ-026 i_awk outside REQ ignored.
REQ-027 FAULT: o_fault=1, o_valid=0, o_instruction_request=0; exit only by i_redirect (-> REQ, o_fault=0 next cycle) or reset.

Reset
REQ-028 i_rst=1 at clock edge: state=IDLE, pc=RESET_PC, o_instr=0, o_instr_pc=0, o_valid=0, o_instruction_request=0, o_fault=0, timeout counter=0.
REQ-029 Reset overrides redirect, ack and ready in same cycle; any in-flight request abandoned.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: saturating counter clears on REQ entry, increments each REQ cycle with i_awk=0; reaching TIMEOUT_CYCLES -> FAULT.
REQ-031 i_awk in the cycle the counter reaches TIMEOUT_CYCLES takes precedence (-> VALID, no fault).
REQ-032 FETCH_TIMEOUT_EN undefined: no counter, FAULT unreachable, REQ waits indefinitely, o_fault tied 0.

Verification
REQ-033 Reset, RESET_PC=0, i_awk one cycle after request with 0x00000013, i_ready=1 -> o_valid with o_instr=0x00000013, o_instr_pc=0; next o_mem_pc=1.
REQ-034 VALID, i_ready=0 for 5 cycles -> o_instr/o_instr_pc unchanged, no request; i_ready=1 -> pc+4 requested.
REQ-035 i_redirect=1, i_redirect_pc=0x0000_0103, coincident with i_awk -> data dropped, next o_mem_pc=0x40, o_instr_pc later 0x100.
REQ-036 pc=0xFFFF_FFFC accepted -> next o_mem_pc=0.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, i_awk held 0 -> o_fault=1 after 16 REQ cycles, request low; redirect clears fault and resumes; macro undefined -> request held, o_fault=0.
REQ-038 i_rst asserted while in VALID with i_ready=1 -> all outputs at reset values next cycle, pc=RESET_PC.
